// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop line synchroniser, 16x oversampled start detection,
// 3-sample majority vote per bit, optional parity, valid/ack output handshake.
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_serial,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int          IDX_W     = $clog2(DATA_BITS);
    localparam logic [3:0]  TCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]  TCNT_S0   = 4'd7;
    localparam logic [3:0]  TCNT_S1   = 4'd8;
    localparam logic [3:0]  TCNT_VOTE = 4'd9;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [3:0]             tcnt_q, tcnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   armed_q, armed_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;
    logic                   voted;

    assign rx_s  = sync2_q;
    assign voted = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_comb begin
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        bit_idx_d    = bit_idx_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        armed_d      = armed_q | rx_s;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q & ~rx_ack;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;

        if (sample_tick) begin
            if (state_q != IDLE) begin
                tcnt_d = tcnt_q + 4'd1;
                if (tcnt_q == TCNT_S0) samp_d[0] = rx_s;
                if (tcnt_q == TCNT_S1) samp_d[1] = rx_s;
            end
            unique case (state_q)
                IDLE: begin
                    // armed blocks a held-low line (break) from retriggering
                    if (!rx_s && armed_q) begin
                        state_d = START;
                        tcnt_d  = 4'd0;
                    end
                end
                START: begin
                    if (tcnt_q == TCNT_VOTE && voted) begin
                        state_d = IDLE;
                        tcnt_d  = 4'd0;
                    end else if (tcnt_q == TCNT_LAST) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        par_en_d  = parity_en;
                        par_odd_d = parity_odd;
                    end
                end
                DATA: begin
                    if (tcnt_q == TCNT_VOTE) begin
                        shift_d = {voted, shift_q[DATA_BITS-1:1]};
                    end
                    if (tcnt_q == TCNT_LAST) begin
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tcnt_q == TCNT_VOTE) par_bit_d = voted;
                    if (tcnt_q == TCNT_LAST) state_d = STOP;
                end
                STOP: begin
                    if (tcnt_q == TCNT_VOTE) begin
                        state_d      = IDLE;
                        tcnt_d       = 4'd0;
                        rx_data_d    = shift_q;
                        frame_err_d  = ~voted;
                        parity_err_d = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);
                        rx_valid_d   = 1'b1;
                        overrun_d    = rx_valid_q & ~rx_ack;
                        if (!voted) armed_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            tcnt_q       <= 4'd0;
            bit_idx_q    <= '0;
            samp_q       <= 2'b00;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            armed_q      <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= rx_serial;
            sync2_q      <= sync1_q;
            tcnt_q       <= tcnt_d;
            bit_idx_q    <= bit_idx_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            armed_q      <= armed_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: directed frames push expected words,
// a negedge monitor pops and compares each word the receiver presents.
module tb_uart_rx_sampler;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_serial = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   words_seen = 0;
    int   ovr_pulses = 0;
    bit   auto_ack = 1'b0;
    bit   ack_req = 1'b0;
    logic valid_prev = 1'b0;

    uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sample_tick(sample_tick),
        .rx_serial  (rx_serial),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    // One sample_tick every 4 clocks, changed on the falling edge.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge clk_in);
            phase = (phase + 1) % 4;
            sample_tick = (phase == 0);
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Consumer side: acks whenever requested and a word is present.
    initial begin
        forever begin
            @(negedge clk_in);
            rx_ack = rx_valid && (auto_ack || ack_req);
        end
    end

    // Monitor: a new word is a rising rx_valid or an overrun overwrite.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (overrun === 1'b1) ovr_pulses++;
            if (rx_valid === 1'b1 && (valid_prev !== 1'b1 || overrun === 1'b1)) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h expected none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                    checkOutput("frame_err", 32'(frame_err), 32'(e.ferr));
                    checkOutput("parity_err", 32'(parity_err), 32'(e.perr));
                    checkOutput("overrun", 32'(overrun), 32'(e.ovr));
                end
            end
            valid_prev = rx_valid;
        end
    end

    task automatic wait_tick();
        int guard;
        guard = 0;
        @(posedge clk_in);
        while (sample_tick !== 1'b1 && guard < 50) begin
            @(posedge clk_in);
            guard++;
        end
        if (guard >= 50) checkOutput("tick_timeout", 32'(guard), 32'd0);
        #1;
    endtask

    task automatic send_bit(input logic v, input int n);
        rx_serial = v;
        repeat (n) wait_tick();
    endtask

    task automatic expect_word(input logic [7:0] d, input logic ferr, input logic perr, input logic ovr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.perr = perr;
        e.ovr  = ovr;
        exp_q.push_back(e);
    endtask

    // One frame; glitch_bit >= 0 flips that data bit for the single tcnt=8 sample.
    task automatic applyStimulus(input logic [7:0] data, input bit pen, input bit pbit,
                                 input bit stop, input int glitch_bit);
        parity_en  = pen;
        parity_odd = 1'b0;
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                send_bit(data[i], 9);
                send_bit(~data[i], 1);
                send_bit(data[i], 6);
            end else begin
                send_bit(data[i], 16);
            end
        end
        if (pen) send_bit(pbit, 16);
        send_bit(stop, 16);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge clk_in);
            guard++;
        end
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic manual_ack();
        @(posedge clk_in);
        #1 ack_req = 1'b1;
        @(negedge clk_in);
        checkOutput("valid_before_ack", 32'(rx_valid), 32'd1);
        @(negedge clk_in);
        checkOutput("valid_after_ack", 32'(rx_valid), 32'd0);
        ack_req = 1'b0;
    endtask

    initial begin
        int w0;
        int o0;

        $display("[TB] reset");
        do_reset();
        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'd0);
        checkOutput("reset_ferr", 32'(frame_err), 32'd0);
        checkOutput("reset_perr", 32'(parity_err), 32'd0);
        checkOutput("reset_ovr", 32'(overrun), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        $display("[TB] basic 0xA5");
        wait_tick();
        expect_word(8'hA5, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        wait_drain();
        checkOutput("basic_hold", 32'(rx_data), 32'hA5);
        manual_ack();

        $display("[TB] parity");
        auto_ack = 1'b1;
        wait_tick();
        expect_word(8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, -1);
        expect_word(8'h3C, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        wait_drain();

        $display("[TB] false start and glitch");
        parity_en = 1'b0;
        w0 = words_seen;
        send_bit(1'b0, 3);
        checkOutput("glitch_busy_high", 32'(busy), 32'd1);
        send_bit(1'b1, 30);
        checkOutput("glitch_busy_low", 32'(busy), 32'd0);
        checkOutput("glitch_no_word", 32'(words_seen - w0), 32'd0);
        expect_word(8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 3);
        wait_drain();

        $display("[TB] stop bit low");
        expect_word(8'h55, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, -1);
        send_bit(1'b1, 16);
        wait_drain();

        $display("[TB] overrun");
        auto_ack = 1'b0;
        o0 = ovr_pulses;
        expect_word(8'h11, 1'b0, 1'b0, 1'b0);
        expect_word(8'h22, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b1, -1);
        wait_drain();
        checkOutput("overrun_pulses", 32'(ovr_pulses - o0), 32'd1);
        checkOutput("overrun_data", 32'(rx_data), 32'h22);
        manual_ack();
        auto_ack = 1'b1;

        $display("[TB] reset mid-frame");
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 16);
        do_reset();
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_valid", 32'(rx_valid), 32'd0);
        rx_serial = 1'b1;
        wait_tick();
        send_bit(1'b1, 20);
        expect_word(8'h0F, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1, -1);
        wait_drain();

        $display("[TB] back-to-back");
        w0 = words_seen;
        o0 = ovr_pulses;
        expect_word(8'h01, 1'b0, 1'b0, 1'b0);
        expect_word(8'h80, 1'b0, 1'b0, 1'b0);
        expect_word(8'hFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, -1);
        wait_drain();
        checkOutput("b2b_words", 32'(words_seen - w0), 32'd3);
        checkOutput("b2b_overrun", 32'(ovr_pulses - o0), 32'd0);

        $display("[TB] line break");
        w0 = words_seen;
        expect_word(8'h00, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 16 * 12);
        checkOutput("break_words", 32'(words_seen - w0), 32'd1);
        checkOutput("break_busy", 32'(busy), 32'd0);
        send_bit(1'b1, 16);
        expect_word(8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1, -1);
        wait_drain();
        checkOutput("break_recover_words", 32'(words_seen - w0), 32'd2);

        repeat (4) @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receive stage that consumes the 16x oversampling tick produced by the baud generator and turns the serial line into parallel bytes. It synchronises the asynchronous `rx_serial` input and detects the start bit. Each bit is recovered by majority vote of three mid-bit samples, with optional parity and a stop-bit check. Received words go to the downstream consumer over a valid/acknowledge handshake. The block sits between the baud generator and the receive FIFO / host register interface, entirely in the `clk_in` domain.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5..8, LSB first.
- `OVERSAMPLE`, 16: `sample_tick` pulses per bit period; fixed at 16 (sample points below assume 16).
- `clk_in`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset: one clock; reset is synchronous and active-high.
- `sample_tick`  input  1  one-`clk_in`-cycle enable at 16x baud rate, from baud generator.
- `rx_serial`  input  1  asynchronous serial line, idle high.
- `parity_en`  input  1  1 = a parity bit follows the data bits.
- `parity_odd`  input  1  1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `rx_ack`  input  1  consumer accepts the current word.
- `rx_data`  output  DATA_BITS  received word, stable while `rx_valid`=1.
- `rx_valid`  output  1  word available; held until acknowledged.
- `frame_err`  output  1  stop bit sampled low for the word in `rx_data`.
- `parity_err`  output  1  parity mismatch for the word in `rx_data`.
- `overrun`  output  1  one-cycle pulse: a word completed while `rx_valid` was still 1.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- **Synchroniser:** `rx_serial` passes through 2 flops, both reset to 1. All decisions use the synchronised value `rx_s`.
- **Counters:**
  - 4-bit tick counter `tcnt` advances only on `sample_tick`, wraps 15 -> 0.
  - Bit index counter runs 0..DATA_BITS-1.
  - Samples are taken on ticks where `tcnt` = 7, 8 and 9.
  - On the `tcnt`=9 tick, the bit value is the majority of the three samples.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** on a `sample_tick` with `rx_s`=0 -> START, `tcnt` <= 0.
  - **START:** at `tcnt`=9, majority 1 -> IDLE (false start, nothing reported). Majority 0 -> stay in START until `tcnt`=15, then -> DATA with bit index 0.
  - **DATA:** at `tcnt`=9, shift the voted bit in LSB first. At `tcnt`=15, if bit index = DATA_BITS-1 go to PARITY (when `parity_en`=1) or STOP; otherwise increment the bit index.
  - **PARITY:** at `tcnt`=9, capture the voted bit. At `tcnt`=15 -> STOP.
  - **STOP:** at `tcnt`=9, vote the stop bit and complete the word, then -> IDLE on the same edge. The back half of the stop bit is not waited for, so the receiver resynchronises early.
- **Completion** (registered on the STOP decision edge):
  - `rx_data` <= shift register.
  - `frame_err` <= ~stop.
  - `parity_err` <= `parity_en` & (XOR(data, parity bit) != `parity_odd`).
  - `rx_valid` <= 1.
  - If `rx_valid` was already 1 and not being acknowledged that cycle: `rx_data` and the flags are overwritten and `overrun` pulses 1 for one cycle.
- **Handshake:** `rx_valid` clears on the cycle after `rx_ack`=1 is seen with `rx_valid`=1. `rx_ack` while `rx_valid`=0 is ignored. Completion in the same cycle as an ack: the new word loads, `rx_valid` stays 1, no overrun.
- **Configuration:** `parity_en` and `parity_odd` are sampled when leaving START. Changes mid-frame do not affect the current frame.

## Timing
- **Reset values:**
  - FSM state = IDLE, counters = 0.
  - `rx_data` = 0; `rx_valid`, `frame_err`, `parity_err`, `overrun`, `busy` all 0.
  - Synchroniser flops = 1.
- **Reset mid-frame:** the frame is abandoned with no output. Reset has priority over every other event.
- **Start latency:** 2 `clk_in` cycles of synchroniser delay, plus detection at the next `sample_tick`.
- **Frame latency:**
  - `rx_valid` rises 1 `clk_in` cycle after the STOP `tcnt`=9 tick edge.
  - That is about (1 + DATA_BITS + `parity_en`) x 16 + 10 ticks after start detection.
- **Tick cadence:** a `sample_tick` arriving on consecutive clocks is legal; each pulse counts once. Without ticks the FSM holds its state indefinitely.
- **Back-to-back frames:** a new start edge is accepted from the first `sample_tick` after returning to IDLE.
- **Line break** (line held low): produces a word of 0x00 with `frame_err`=1. The next frame is not recognised until the line has been seen high at least once and then falls again.

## Test plan
- **Basic receive:** reset, then send 0xA5 (8N1, 16 ticks/bit, 1 tick per 4 clocks) -> `rx_data`=0xA5, `rx_valid`=1, `frame_err`=0, `parity_err`=0. After `rx_ack`, `rx_valid`=0 next cycle.
- **Parity:** `parity_en`=1, `parity_odd`=0, send 0x3C with parity bit 0 -> no error. Repeat with parity bit 1 -> `parity_err`=1, `rx_data`=0x3C.
- **False start / glitch:**
  - 3-tick low glitch on an idle line -> no `rx_valid`, back in IDLE, `busy`=0.
  - A single-tick 1 at sample 8 of a data bit of 0x00 -> still 0x00 (majority vote).
- **Errors:**
  - Stop bit held low while sending 0x55 -> `frame_err`=1, `rx_data`=0x55.
  - Send 0x11 then 0x22 without ack -> `overrun` pulses once, `rx_data`=0x22, `rx_valid`=1.
- **Reset mid-frame:** assert `rst` after data bit 3 of 0xF0, then send 0x0F -> only 0x0F is reported, all flags 0.
- **Back-to-back:** three frames 0x01, 0x80, 0xFF with no idle gap, each acked immediately -> three `rx_valid` pulses, correct data, no `overrun`.
